// File: rtl/ifstage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   if_state_e : fetch FSM state encoding
//   NopInsn    : instruction written into IF/ID on a redirect (all zeros)
//   PcInc      : sequential PC increment in bytes
package ifstage_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StKill  = 2'd3
  } if_state_e;

  localparam logic [31:0] NopInsn = 32'h0000_0000;
  localparam int unsigned PcInc   = 4;

endpackage

// File: rtl/ifstage_pcreg.sv
// Program counter register for the fetch stage.
//   clk, rstn     : clock, asynchronous active-low reset (pc -> RESETPC)
//   load          : update pc this cycle
//   sel_redirect  : 1 selects the word-aligned redirect target, 0 selects pc+4
//   redirectpc    : redirect target; low two bits are ignored
//   pc            : current program counter
//   pc_plus4      : pc + 4, modulo 2^AWIDTH
module ifstage_pcreg
  import ifstage_pkg::*;
#(
  parameter int unsigned       AWIDTH  = 32,
  parameter logic [AWIDTH-1:0] RESETPC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              sel_redirect,
  input  logic [AWIDTH-1:0] redirectpc,
  output logic [AWIDTH-1:0] pc,
  output logic [AWIDTH-1:0] pc_plus4
);

  logic [AWIDTH-1:0] pc_q, pc_d, target;

  // Masking (rather than slicing) keeps every bit of redirectpc in use.
  assign target   = redirectpc & ~AWIDTH'(3);
  assign pc_plus4 = pc_q + AWIDTH'(PcInc);
  assign pc_d     = sel_redirect ? target : pc_plus4;
  assign pc       = pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESETPC;
    end else if (load) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/ifstage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory over a
// request/ready handshake and writes {instruction, PC+4} into IF/ID.
//   clk, rstn            : clock, asynchronous active-low reset
//   imreq, imaddr        : memory request and address (held until imrdy)
//   imrdy, imdata        : memory completion and returned instruction
//   stall                : decode cannot accept; fetched word parks in holdbuf
//   redirect, redirectpc : taken branch/jump; writes a NOP and refetches
//   insout, pcnextout    : IF/ID data
//   ifidwr               : IF/ID write strobe
module ifstage
  import ifstage_pkg::*;
#(
  parameter int unsigned       INSWIDTH = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESETPC  = '0
) (
  input  logic                clk,
  input  logic                rstn,
  output logic                imreq,
  output logic [AWIDTH-1:0]   imaddr,
  input  logic                imrdy,
  input  logic [INSWIDTH-1:0] imdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [AWIDTH-1:0]   redirectpc,
  output logic [INSWIDTH-1:0] insout,
  output logic [AWIDTH-1:0]   pcnextout,
  output logic                ifidwr
);

  if_state_e           state_q, state_d;
  logic [INSWIDTH-1:0] hold_ins_q;
  logic [AWIDTH-1:0]   hold_pcn_q;
  logic [AWIDTH-1:0]   kill_addr_q;
  logic [AWIDTH-1:0]   pc, pc_plus4;
  logic                pc_load, pc_sel_redir;
  logic                hold_load, hold_clear, kill_load;

  ifstage_pcreg #(
    .AWIDTH  (AWIDTH),
    .RESETPC (RESETPC)
  ) u_pcreg (
    .clk          (clk),
    .rstn         (rstn),
    .load         (pc_load),
    .sel_redirect (pc_sel_redir),
    .redirectpc   (redirectpc),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      hold_ins_q  <= '0;
      hold_pcn_q  <= '0;
      kill_addr_q <= RESETPC;
    end else begin
      state_q <= state_d;
      if (hold_clear) begin
        hold_ins_q <= '0;
        hold_pcn_q <= '0;
      end else if (hold_load) begin
        hold_ins_q <= imdata;
        hold_pcn_q <= pc_plus4;
      end
      // The PC moves to the redirect target right away, so the address of
      // the request that cannot be retracted is kept here.
      if (kill_load) begin
        kill_addr_q <= pc;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    imreq        = 1'b0;
    imaddr       = pc;
    insout       = '0;
    pcnextout    = '0;
    ifidwr       = 1'b0;
    pc_load      = 1'b0;
    pc_sel_redir = 1'b0;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    kill_load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (redirect) begin
          pc_load      = 1'b1;
          pc_sel_redir = 1'b1;
        end
      end

      StFetch: begin
        imreq = 1'b1;
        if (redirect) begin
          insout       = INSWIDTH'(NopInsn);
          ifidwr       = 1'b1;
          pc_load      = 1'b1;
          pc_sel_redir = 1'b1;
          if (!imrdy) begin
            kill_load = 1'b1;
            state_d   = StKill;
          end
        end else if (imrdy) begin
          if (!stall) begin
            insout    = imdata;
            pcnextout = pc_plus4;
            ifidwr    = 1'b1;
            pc_load   = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_d   = StHold;
          end
        end
      end

      StHold: begin
        if (redirect) begin
          insout       = INSWIDTH'(NopInsn);
          ifidwr       = 1'b1;
          pc_load      = 1'b1;
          pc_sel_redir = 1'b1;
          hold_clear   = 1'b1;
          state_d      = StFetch;
        end else begin
          insout    = hold_ins_q;
          pcnextout = hold_pcn_q;
          ifidwr    = !stall;
          if (!stall) begin
            pc_load = 1'b1;
            state_d = StFetch;
          end
        end
      end

      StKill: begin
        imreq  = 1'b1;
        imaddr = kill_addr_q;
        if (redirect) begin
          insout       = INSWIDTH'(NopInsn);
          ifidwr       = 1'b1;
          pc_load      = 1'b1;
          pc_sel_redir = 1'b1;
        end else if (imrdy) begin
          state_d = StFetch;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ifstage.sv
module tb_ifstage;

  localparam logic [31:0] RstPc = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imreq, imrdy, stall, redirect, ifidwr;
  logic [31:0] imaddr, imdata, redirectpc, insout, pcnextout;

  always #5 clk = ~clk;

  ifstage #(
    .INSWIDTH (32),
    .AWIDTH   (32),
    .RESETPC  (RstPc)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imreq      (imreq),
    .imaddr     (imaddr),
    .imrdy      (imrdy),
    .imdata     (imdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirectpc (redirectpc),
    .insout     (insout),
    .pcnextout  (pcnextout),
    .ifidwr     (ifidwr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: where the stage is in its fetch life-cycle.
  bit          m_started, m_draining, m_holding;
  logic [31:0] m_pc, m_drain_addr, m_hins, m_hpcn;
  // Handshake watcher on the observed bus.
  bit          p_pending;
  logic [31:0] p_addr;
  // Last observed outputs, for directed checks.
  logic        o_req, o_wr;
  logic [31:0] o_addr, o_ins, o_pcn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_started  = 0;
    m_draining = 0;
    m_holding  = 0;
    m_pc       = RstPc;
    m_drain_addr = RstPc;
    m_hins     = '0;
    m_hpcn     = '0;
    p_pending  = 0;
  endtask

  // Called just after a rising edge; asserts reset asynchronously.
  task automatic do_reset();
    imrdy = 0; stall = 0; redirect = 0; redirectpc = '0; imdata = '0;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_imreq", imreq, 0);
    chk("rst_imaddr", imaddr, RstPc);
    chk("rst_insout", insout, 0);
    chk("rst_pcnext", pcnextout, 0);
    chk("rst_ifidwr", ifidwr, 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  // One clock cycle: drive, predict, compare, advance.
  task automatic cycle(input logic rdy, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] data);
    logic        e_req, e_wr;
    logic [31:0] e_addr, e_ins, e_pcn, tgt;
    imrdy = rdy; stall = st; redirect = rd; redirectpc = rpc; imdata = data;
    #3;
    tgt   = rpc & 32'hFFFF_FFFC;
    e_req = 0; e_wr = 0; e_addr = m_pc; e_ins = 0; e_pcn = 0;
    if (!m_started) begin
      m_started = 1;
      if (rd) m_pc = tgt;
    end else if (m_holding) begin
      if (rd) begin
        e_wr = 1; m_pc = tgt; m_holding = 0;
      end else begin
        e_ins = m_hins; e_pcn = m_hpcn; e_wr = !st;
        if (!st) begin m_pc = m_pc + 4; m_holding = 0; end
      end
    end else if (m_draining) begin
      e_req = 1; e_addr = m_drain_addr;
      if (rd) begin
        e_wr = 1; m_pc = tgt;
      end else if (rdy) begin
        m_draining = 0;
      end
    end else begin
      e_req = 1;
      if (rd) begin
        e_wr = 1;
        if (!rdy) begin m_draining = 1; m_drain_addr = m_pc; end
        m_pc = tgt;
      end else if (rdy && !st) begin
        e_ins = data; e_pcn = m_pc + 4; e_wr = 1; m_pc = m_pc + 4;
      end else if (rdy) begin
        m_hins = data; m_hpcn = m_pc + 4; m_holding = 1;
      end
    end
    o_req = imreq; o_wr = ifidwr; o_addr = imaddr; o_ins = insout; o_pcn = pcnextout;
    chk("imreq", imreq, e_req);
    chk("imaddr", imaddr, e_addr);
    chk("ifidwr", ifidwr, e_wr);
    chk("insout", insout, e_ins);
    chk("pcnextout", pcnextout, e_pcn);
    if (p_pending) begin
      chk("req_held", imreq, 1);
      chk("addr_held", imaddr, p_addr);
    end
    p_pending = imreq && !rdy;
    p_addr    = imaddr;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d;

  initial begin
    rstn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait sequential fetch from RESETPC.
    do_reset();
    cycle(1, 0, 0, 0, 32'h1111_0001);
    chk("tp1_idle_req", o_req, 0);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      cycle(1, 0, 0, 0, d);
      chk("tp1_addr", o_addr, RstPc + 32'(4 * i));
      chk("tp1_pcn", o_pcn, RstPc + 32'(4 * i + 4));
      chk("tp1_wr", o_wr, 1);
      chk("tp1_ins", o_ins, d);
    end

    // Reset lands mid-request; then three wait states at 0x400.
    do_reset();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, $urandom);
      chk("tp2_addr", o_addr, 32'h400);
      chk("tp2_wr", o_wr, 0);
    end
    d = $urandom;
    cycle(1, 0, 0, 0, d);
    chk("tp2_ins", o_ins, d);

    // Two-cycle stall coinciding with completion at 0x404.
    d = $urandom;
    cycle(1, 1, 0, 0, d);
    chk("tp3_wr0", o_wr, 0);
    cycle(0, 1, 0, 0, 0);
    chk("tp3_hold_req", o_req, 0);
    chk("tp3_hold_wr", o_wr, 0);
    cycle(0, 0, 0, 0, 0);
    chk("tp3_rel_ins", o_ins, d);
    chk("tp3_rel_pcn", o_pcn, 32'h408);
    cycle(0, 0, 0, 0, 0);
    chk("tp3_next_addr", o_addr, 32'h408);

    // Redirect while 0x408 is outstanding (target low bits are ignored).
    cycle(0, 0, 1, 32'h1002, 0);
    chk("tp4_nop_wr", o_wr, 1);
    chk("tp4_nop_ins", o_ins, 0);
    cycle(0, 0, 0, 0, 0);
    chk("tp4_kill_addr", o_addr, 32'h408);
    cycle(1, 0, 0, 0, 32'hDEAD_BEEF);
    chk("tp4_drop_wr", o_wr, 0);
    cycle(1, 0, 0, 0, 32'h0BAD_F00D);
    chk("tp4_target", o_addr, 32'h1000);

    // Redirect together with stall while holding.
    cycle(1, 1, 0, 0, $urandom);
    cycle(0, 1, 1, 32'h2000, 0);
    chk("tp5_nop_wr", o_wr, 1);
    chk("tp5_nop_ins", o_ins, 0);
    cycle(1, 0, 0, 0, $urandom);
    chk("tp5_target", o_addr, 32'h2000);

    // PC wrap at the top of the address space.
    cycle(1, 0, 1, 32'hFFFF_FFFC, $urandom);
    cycle(1, 0, 0, 0, $urandom);
    chk("tp6_addr", o_addr, 32'hFFFF_FFFC);
    chk("tp6_pcn", o_pcn, 32'h0000_0000);
    cycle(1, 0, 0, 0, $urandom);
    chk("tp6_wrap", o_addr, 32'h0000_0000);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
            32'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifstage.md
# ifstage

Instruction-fetch stage of the five-stage pipeline: owns the program counter, issues requests to instruction memory over a request/ready handshake, and presents each fetched instruction with its PC+4 to the IF/ID pipeline register. It drives that register's write strobe. The stage absorbs memory wait states, honours decode-stage stalls through a one-entry hold buffer, and services branch/jump redirects by squashing in-flight fetches and writing a NOP into IF/ID.

## Interface
- INSWIDTH, 32, instruction width
- AWIDTH, 32, address width
- RESETPC, 0, PC loaded at reset
- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low
- imreq  out  1  fetch request to instruction memory
- imaddr  out  AWIDTH  fetch address, equals PC
- imrdy  in  1  memory completes request; imdata valid this cycle
- imdata  in  INSWIDTH  fetched instruction
- stall  in  1  decode stage cannot accept a new instruction
- redirect  in  1  branch/jump taken; flush and refetch
- redirectpc  in  AWIDTH  redirect target; bits [1:0] forced to 0
- insout  out  INSWIDTH  instruction to IF/ID
- pcnextout  out  AWIDTH  PC+4 to IF/ID
- ifidwr  out  1  IF/ID write strobe

## Operation
- States: IDLE, FETCH, HOLD, KILL. Reset: state=IDLE, pc=RESETPC, holdbuf cleared.
- Memory rule: once imreq=1, imreq and imaddr stay constant until the cycle with imrdy=1. Transfer completes only when imreq&imrdy. Outstanding requests cannot be retracted.
- IDLE: imreq=0, ifidwr=0. Next cycle FETCH. If redirect=1, pc<=redirectpc.
- FETCH: imreq=1, imaddr=pc.
  - imrdy=1, stall=0: insout=imdata, pcnextout=pc+4, ifidwr=1, pc<=pc+4, stay FETCH.
  - imrdy=1, stall=1: holdbuf<={imdata,pc+4}, ifidwr=0, go HOLD.
  - imrdy=0: ifidwr=0, stay FETCH.
- HOLD: imreq=0, insout/pcnextout from holdbuf, ifidwr=!stall. When stall=0: pc<=pc+4, go FETCH.
- Redirect overrides stall and every other transition. In all non-IDLE states, redirect=1 forces insout=0 (NOP), pcnextout=0, ifidwr=1, and pc<=redirectpc. Next state by condition:
  - FETCH with imrdy=1: FETCH.
  - FETCH with imrdy=0: KILL.
  - HOLD: FETCH; holdbuf discarded.
  - KILL: stay KILL.
- KILL: imreq=1 with the old address held, ifidwr=0, imdata discarded. On imrdy=1, go FETCH, which fetches the redirect target.
- Arithmetic: pc+4 is modulo 2^AWIDTH; 0xFFFFFFFC wraps to 0.

## Timing
- Reset values: imreq=0, imaddr=RESETPC, insout=0, pcnextout=0, ifidwr=0.
- First request: imreq=1 in the second cycle after rstn deasserts.
- Zero-wait memory gives one instruction per cycle, with ifidwr=1 in the same cycle as imrdy.
- Output paths are combinational from imdata/imrdy/stall/redirect and registered state; IF/ID captures on the following clock edge.
- Stall release: the buffered instruction is written in the first cycle with stall=0, and the next request issues the cycle after.
- Redirect during an outstanding fetch adds the remaining wait cycles plus one request cycle before the target's instruction appears.
- If rstn asserts mid-request, imreq drops immediately (asynchronous reset) and the outstanding memory transaction is abandoned.

## Structure
- Shared package: state encoding, NOP constant (all zeros), and the PC increment constant 4.
- Natural sub-module: pcreg, the PC register with asynchronous reset to RESETPC, a load-enable, and a select between pc+4 and redirectpc.
- The FSM, hold buffer, and output muxing live in ifstage.

## Test plan
- Reset with RESETPC=0x400, imrdy tied 1 → cycle 1 imreq=0; then imaddr 0x400, 0x404, 0x408 with ifidwr=1 and pcnextout 0x404, 0x408, 0x40C.
- imrdy low for 3 cycles at 0x400 → imaddr held at 0x400, ifidwr=0 for 3 cycles, then insout=imdata.
- stall=1 for 2 cycles coinciding with imrdy at 0x404 → HOLD, imreq=0, ifidwr=0; on release insout equals the captured word and pcnextout=0x408; next imaddr=0x408.
- redirect to 0x1000 while imaddr=0x408 is outstanding and imrdy=0 → NOP written (ifidwr=1, insout=0); 0x408 held until imrdy, its data dropped; next imaddr=0x1000.
- redirect and stall both 1 in HOLD → NOP written, holdbuf dropped, next imaddr=redirect target.
- redirect to 0xFFFFFFFC with zero-wait memory → pcnextout=0x00000000, next imaddr=0x00000000.
